avalon_slave_frontend: RTL and testbench

//  Avalon-MM slave front end sitting directly upstream of the block-RAM memory adapter.
//  - Converts master byte addresses to word addresses.
//  - Removes the write-then-read old-data hazard by stalling the read one cycle.
//  - Bounds outstanding reads.
//  - Returns SLAVEERROR with zero data for out-of-range reads.
//  - Registers the read response path back to the master.

---
 rtl/avalon_slave_frontend.sv | 194 +++++++++++++++++++
 tb/tb_avalon_slave_frontend.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_slave_frontend.sv
// ---------------------------------------------------------------------------
// avalon_slave_frontend
//
// Avalon-MM slave front end placed directly in front of the block-RAM memory
// adapter. It turns master byte addresses into word addresses. It stalls a
// read that immediately follows a write to the same word, so that the read
// never sees the old data. It limits the number of reads in flight. Reads
// outside the memory return SLAVEERROR with zero data. The read response is
// registered on its way back to the master.
//
// Ports
//   clk_i               system clock, all state on the rising edge
//   reset_n_i           asynchronous active-low reset
//   avs_read_i          master read request
//   avs_write_i         master write request
//   avs_address_i       master byte address
//   avs_writedata_i     master write data
//   avs_waitrequest_o   request not accepted this cycle (reads only)
//   avs_readdata_o      registered read data
//   avs_readdatavalid_o avs_readdata_o / avs_response_o valid
//   avs_response_o      2'b00 OKAY, 2'b10 SLAVEERROR
//   mem_read_o          read strobe to the adapter
//   mem_write_o         write strobe to the adapter
//   mem_address_o       word address to the adapter
//   mem_data_in_o       write data to the adapter (pass-through)
//   mem_read_valid_i    adapter read_valid
//   mem_data_out_i      adapter read data
// ---------------------------------------------------------------------------
module avalon_slave_frontend #(
    parameter int BUSWIDTH      = 32,
    parameter int DATADEPTH     = 1024,
    parameter int LATENCY       = 1,
    parameter int MAX_PENDING   = 4,
    parameter int AVS_ADDRWIDTH = 32,
    parameter int ADDRESSWIDTH  = $clog2(DATADEPTH)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     avs_read_i,
    input  logic                     avs_write_i,
    input  logic [AVS_ADDRWIDTH-1:0] avs_address_i,
    input  logic [BUSWIDTH-1:0]      avs_writedata_i,
    output logic                     avs_waitrequest_o,
    output logic [BUSWIDTH-1:0]      avs_readdata_o,
    output logic                     avs_readdatavalid_o,
    output logic [1:0]               avs_response_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic [ADDRESSWIDTH-1:0]  mem_address_o,
    output logic [BUSWIDTH-1:0]      mem_data_in_o,
    input  logic                     mem_read_valid_i,
    input  logic [BUSWIDTH-1:0]      mem_data_out_i
);

    localparam int BYTE_SHIFT = $clog2(BUSWIDTH / 8);
    localparam int PEND_W     = $clog2(MAX_PENDING + 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [AVS_ADDRWIDTH-1:0] waddr;
    logic                     oor;

    assign waddr = avs_address_i >> BYTE_SHIFT;
    assign oor   = (waddr >= AVS_ADDRWIDTH'(DATADEPTH));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                    raw_vld_q,  raw_vld_d;
    logic [ADDRESSWIDTH-1:0] raw_addr_q, raw_addr_d;
    logic [PEND_W-1:0]       pending_q,  pending_d;
    logic [LATENCY-1:0]      trk_vld_q,  trk_vld_d;
    logic [LATENCY-1:0]      trk_err_q,  trk_err_d;
    logic                    rvalid_q,   rvalid_d;
    logic [BUSWIDTH-1:0]     rdata_q,    rdata_d;
    logic [1:0]              resp_q,     resp_d;

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    logic rd_req;
    logic raw_hit;
    logic pend_full;
    logic rd_acc;
    logic wr_acc;
    logic tail_vld;
    logic tail_err;

    // A read presented together with a write is ignored, so it must not
    // stall the write either.
    assign rd_req  = avs_read_i && !avs_write_i;
    assign raw_hit = raw_vld_q && (waddr == AVS_ADDRWIDTH'(raw_addr_q));
    // The slot held by the response currently on the bus frees this cycle,
    // so a full tracker still accepts a read when a response is retiring.
    assign pend_full = (pending_q == PEND_W'(MAX_PENDING)) && !rvalid_q;

    assign avs_waitrequest_o = !reset_n_i || (rd_req && (raw_hit || pend_full));

    assign rd_acc = rd_req && !avs_waitrequest_o;
    assign wr_acc = reset_n_i && avs_write_i;

    assign mem_read_o    = rd_acc && !oor;
    assign mem_write_o   = wr_acc && !oor;
    assign mem_address_o = waddr[ADDRESSWIDTH-1:0];
    assign mem_data_in_o = avs_writedata_i;

    // Only a write that reached the RAM can cause a stale read next cycle.
    assign raw_vld_d  = mem_write_o;
    assign raw_addr_d = mem_write_o ? waddr[ADDRESSWIDTH-1:0] : raw_addr_q;

    // ------------------------------------------------------------------
    // Tracker: runs in lockstep with the adapter's read pipeline
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_trk
            if (gi == 0) begin : g_head
                assign trk_vld_d[gi] = rd_acc;
                assign trk_err_d[gi] = rd_acc && oor;
            end else begin : g_body
                assign trk_vld_d[gi] = trk_vld_q[gi-1];
                assign trk_err_d[gi] = trk_err_q[gi-1];
            end
        end
    endgenerate

    assign tail_vld = trk_vld_q[LATENCY-1];
    assign tail_err = trk_err_q[LATENCY-1];

    // ------------------------------------------------------------------
    // Pending count: a read counts from acceptance until its response
    // has been shown on the bus.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (rd_acc && !rvalid_q) begin
            pending_d = pending_q + PEND_W'(1);
        end else if (!rd_acc && rvalid_q) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response register; data and response hold when nothing retires
    // ------------------------------------------------------------------
    always_comb begin
        rvalid_d = tail_vld;
        rdata_d  = rdata_q;
        resp_d   = resp_q;
        if (tail_vld) begin
            rdata_d = tail_err ? '0 : mem_data_out_i;
            resp_d  = tail_err ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            raw_vld_q  <= 1'b0;
            raw_addr_q <= '0;
            pending_q  <= '0;
            trk_vld_q  <= '0;
            trk_err_q  <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= 2'b00;
        end else begin
            raw_vld_q  <= raw_vld_d;
            raw_addr_q <= raw_addr_d;
            pending_q  <= pending_d;
            trk_vld_q  <= trk_vld_d;
            trk_err_q  <= trk_err_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
        end
    end

    assign avs_readdatavalid_o = rvalid_q;
    assign avs_readdata_o      = rdata_q;
    assign avs_response_o      = resp_q;

    // ------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------
    // The adapter must return data exactly when a real (non-error) read
    // reaches the tracker tail; otherwise LATENCY is set inconsistently.
    a_tail_sync : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ((tail_vld && !tail_err) == mem_read_valid_i));

    a_no_rd_wr : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(avs_read_i && avs_write_i));

endmodule

// File: tb/tb_avalon_slave_frontend.sv
// Bench for avalon_slave_frontend: two instances, MAX_PENDING=4 and
// MAX_PENDING=1, each with a one-cycle-latency adapter model. Expected read
// responses are queued at acceptance and checked by per-instance monitors.
module tb_avalon_slave_frontend;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- instance 0: MAX_PENDING = 4 ----------------
    logic        rd, wr, waitreq, rvalid, m_rd, m_wr, m_rvalid;
    logic [31:0] addr, wdata, rdata, m_din, m_dout;
    logic [1:0]  resp;
    logic [9:0]  m_addr;

    avalon_slave_frontend #(
        .BUSWIDTH(32), .DATADEPTH(1024), .LATENCY(1), .MAX_PENDING(4), .AVS_ADDRWIDTH(32)
    ) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n),
        .avs_read_i(rd), .avs_write_i(wr), .avs_address_i(addr), .avs_writedata_i(wdata),
        .avs_waitrequest_o(waitreq), .avs_readdata_o(rdata), .avs_readdatavalid_o(rvalid),
        .avs_response_o(resp),
        .mem_read_o(m_rd), .mem_write_o(m_wr), .mem_address_o(m_addr), .mem_data_in_o(m_din),
        .mem_read_valid_i(m_rvalid), .mem_data_out_i(m_dout)
    );

    // Adapter model: unwritten word i reads as 0xA000_0000 + i.
    logic [31:0] mem0 [1024];
    bit          wflag0 [1024];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rvalid <= 1'b0;
            m_dout   <= 32'h0;
        end else begin
            m_rvalid <= m_rd;
            if (m_rd) m_dout <= wflag0[m_addr] ? mem0[m_addr] : (32'hA000_0000 + {22'h0, m_addr});
            if (m_wr) begin
                mem0[m_addr]   <= m_din;
                wflag0[m_addr] <= 1'b1;
            end
        end
    end

    // ---------------- instance 1: MAX_PENDING = 1 ----------------
    logic        rd1, wr1, waitreq1, rvalid1, m_rd1, m_wr1, m_rvalid1;
    logic [31:0] addr1, wdata1, rdata1, m_din1, m_dout1;
    logic [1:0]  resp1;
    logic [9:0]  m_addr1;

    avalon_slave_frontend #(
        .BUSWIDTH(32), .DATADEPTH(1024), .LATENCY(1), .MAX_PENDING(1), .AVS_ADDRWIDTH(32)
    ) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n),
        .avs_read_i(rd1), .avs_write_i(wr1), .avs_address_i(addr1), .avs_writedata_i(wdata1),
        .avs_waitrequest_o(waitreq1), .avs_readdata_o(rdata1), .avs_readdatavalid_o(rvalid1),
        .avs_response_o(resp1),
        .mem_read_o(m_rd1), .mem_write_o(m_wr1), .mem_address_o(m_addr1), .mem_data_in_o(m_din1),
        .mem_read_valid_i(m_rvalid1), .mem_data_out_i(m_dout1)
    );

    // Adapter model: word i reads as 0xB000_0000 + i.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rvalid1 <= 1'b0;
            m_dout1   <= 32'h0;
        end else begin
            m_rvalid1 <= m_rd1;
            if (m_rd1) m_dout1 <= 32'hB000_0000 + {22'h0, m_addr1};
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rvalid === 1'b1) begin
            if (q0.size() == 0) begin
                chk("unexpected_rvalid0", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("rdata0", rdata, e.data);
                chk("resp0", {30'h0, resp}, {30'h0, e.resp});
                chk("latency0", cyc, e.cyc);
                $display("dut0 resp: data=%h resp=%b cycle=%0d", rdata, resp, cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rvalid1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("unexpected_rvalid1", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("rdata1", rdata1, e.data);
                chk("resp1", {30'h0, resp1}, {30'h0, e.resp});
                chk("latency1", cyc, e.cyc);
                $display("dut1 resp: data=%h resp=%b cycle=%0d", rdata1, resp1, cyc);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic idle0();
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic exp_mwr);
        rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        chk("wr_waitreq0", {31'h0, waitreq}, 32'd0);
        chk("mem_write0", {31'h0, m_wr}, {31'h0, exp_mwr});
        if (exp_mwr) chk("wr_addr0", {22'h0, m_addr}, {22'h0, a[11:2]});
        $display("dut0 write: addr=%h data=%h mem_write=%b", a, d, m_wr);
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic rd0(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                       input int exp_stalls);
        int st;
        bit done;
        st = 0; done = 1'b0;
        rd = 1'b1; wr = 1'b0; addr = a;
        while (!done) begin
            @(negedge clk);
            if (!waitreq) begin
                done = 1'b1;
                chk("mem_read0", {31'h0, m_rd}, ((a >> 2) < 1024) ? 32'd1 : 32'd0);
                q0.push_back('{ed, er, cyc + 2});
            end else begin
                st++;
                if (st > 20) begin
                    chk("stall_bound0", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        chk("stalls0", st, exp_stalls);
        $display("dut0 read: addr=%h stalls=%0d", a, st);
    endtask

    task automatic rd1_t(input logic [31:0] a, input logic [31:0] ed, input int exp_stalls);
        int st;
        bit done;
        st = 0; done = 1'b0;
        rd1 = 1'b1; addr1 = a;
        while (!done) begin
            @(negedge clk);
            if (!waitreq1) begin
                done = 1'b1;
                q1.push_back('{ed, 2'b00, cyc + 2});
            end else begin
                st++;
                if (st > 20) begin
                    chk("stall_bound1", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        chk("stalls1", st, exp_stalls);
        $display("dut1 read: addr=%h stalls=%0d", a, st);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        rd = 1'b1; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;

        // 1: reset with a read held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_waitreq", {31'h0, waitreq}, 32'd1);
        chk("rst_mem_read", {31'h0, m_rd}, 32'd0);
        chk("rst_rvalid", {31'h0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", {30'h0, resp}, 32'd0);
        $display("reset: waitreq=%b mem_read=%b rvalid=%b", waitreq, m_rd, rvalid);
        rd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle0();

        // 2: write then read the same word -> one stall
        wr0(32'h0000_0010, 32'hCAFE_F00D, 1'b1);
        rd0(32'h0000_0010, 32'hCAFE_F00D, 2'b00, 1);
        idle0(); idle0();

        // 3: back-to-back reads, no stalls
        rd0(32'h0, 32'hA000_0000, 2'b00, 0);
        rd0(32'h4, 32'hA000_0001, 2'b00, 0);
        rd0(32'h8, 32'hA000_0002, 2'b00, 0);
        rd0(32'hC, 32'hA000_0003, 2'b00, 0);
        rd0(32'h10, 32'hCAFE_F00D, 2'b00, 0);
        idle0(); idle0();

        // 4: out-of-range read between two good reads
        rd0(32'h0, 32'hA000_0000, 2'b00, 0);
        rd0(32'h1000, 32'h0, 2'b10, 0);
        rd0(32'h4, 32'hA000_0001, 2'b00, 0);
        idle0(); idle0();

        // 5: out-of-range write is dropped; following read not stalled
        wr0(32'h1000, 32'hDEAD_BEEF, 1'b0);
        rd0(32'h0, 32'hA000_0000, 2'b00, 0);
        idle0(); idle0(); idle0();

        // 6: reset with two reads in flight (no expectations queued)
        rd = 1'b1; addr = 32'h0;
        @(negedge clk);
        chk("inflight_acc_a", {31'h0, waitreq}, 32'd0);
        @(posedge clk); #1;
        addr = 32'h4;
        @(negedge clk);
        chk("inflight_acc_b", {31'h0, waitreq}, 32'd0);
        #1 rst_n = 1'b0;
        rd = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rvalid_after_rst", {31'h0, rvalid}, 32'd0);
        end
        $display("reset mid-burst: released, no stray responses checked");
        @(posedge clk); #1;
        rd0(32'h8, 32'hA000_0002, 2'b00, 0);
        idle0(); idle0();

        // 3b: MAX_PENDING=1 instance stalls every other cycle
        rd1_t(32'h0, 32'hB000_0000, 0);
        rd1_t(32'h4, 32'hB000_0001, 1);
        rd1_t(32'h8, 32'hB000_0002, 1);
        rd1_t(32'hC, 32'hB000_0003, 1);
        rd1_t(32'h10, 32'hB000_0004, 1);
        rd1 = 1'b0;

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: run did not complete, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
